// File: rtl/grayscale_pack_ci.sv
// Two-pixel RGB565-to-gray custom instruction. A single shared datapath converts
// both pixels. Their gray bytes are packed into a 4-byte word that fills over two calls.
module grayscale_pack_ci #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult
);

    typedef enum logic [1:0] {IDLE, CONV0, CONV1, DONE} state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] pack;
    logic        ptr;

    logic [15:0] pixel;
    logic [13:0] r14, g14, b14;
    logic [13:0] sum;
    logic [7:0]  gray;
    logic [31:0] pack_wr;
    logic        accept;
    logic        unused_ctrl;

    assign unused_ctrl = ^ciValueB[31:2];
    assign accept      = ciStart && (ciN == customInstructionId);

    // One converter shared by both conversion states; the pixel is muxed by state.
    always_comb begin
        pixel = (state == CONV1) ? a_q[31:16] : a_q[15:0];
        r14   = {7'b0, pixel[15:11], 1'b0};
        g14   = {8'b0, pixel[10:5]};
        b14   = {7'b0, pixel[4:0], 1'b0};
        // 54 = 32+16+4+2, 183 = 128+32+16+4+2+1, 19 = 16+2+1
        sum   = (r14 << 5) + (r14 << 4) + (r14 << 2) + (r14 << 1)
              + (g14 << 7) + (g14 << 5) + (g14 << 4) + (g14 << 2) + (g14 << 1) + g14
              + (b14 << 4) + (b14 << 1) + b14;
        gray  = 8'(sum >> 6);
    end

    always_comb begin
        pack_wr = pack;
        case ({ptr, state == CONV1})
            2'b00:   pack_wr[7:0]   = gray;
            2'b01:   pack_wr[15:8]  = gray;
            2'b10:   pack_wr[23:16] = gray;
            default: pack_wr[31:24] = gray;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            pack     <= '0;
            ptr      <= 1'b0;
            ciDone   <= 1'b0;
            ciResult <= '0;
        end else if (ciCke) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= ciValueA;
                        if (ciValueB[0]) begin
                            pack <= '0;
                            ptr  <= 1'b0;
                        end
                        if (ciValueB[1]) begin
                            // Read-only returns the word as it stands after any clear.
                            state    <= DONE;
                            ciDone   <= 1'b1;
                            ciResult <= ciValueB[0] ? '0 : pack;
                        end else begin
                            state <= CONV0;
                        end
                    end
                end
                CONV0: begin
                    pack  <= pack_wr;
                    state <= CONV1;
                end
                CONV1: begin
                    pack     <= pack_wr;
                    ptr      <= ~ptr;
                    state    <= DONE;
                    ciDone   <= 1'b1;
                    ciResult <= pack_wr;
                end
                DONE: begin
                    ciDone   <= 1'b0;
                    ciResult <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grayscale_pack_ci.sv
// Bench for grayscale_pack_ci: directed scenarios plus randomized calls against
// a byte-array model of the pack word.
module tb_grayscale_pack_ci;

    localparam logic [7:0] ID = 8'd5;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;

    int errors = 0;
    int checks = 0;

    logic [7:0] mpack [4];
    int         mptr;

    grayscale_pack_ci #(.customInstructionId(ID)) dut (
        .clock    (clock),
        .reset    (reset),
        .ciStart  (ciStart),
        .ciCke    (ciCke),
        .ciN      (ciN),
        .ciValueA (ciValueA),
        .ciValueB (ciValueB),
        .ciDone   (ciDone),
        .ciResult (ciResult)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gray_ref(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]) * 2;
        g = int'(p[10:5]);
        b = int'(p[4:0]) * 2;
        return 8'((r * 54 + g * 183 + b * 19) / 64);
    endfunction

    function automatic logic [31:0] model_word();
        return {mpack[3], mpack[2], mpack[1], mpack[0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mpack[i] = 8'h00;
        mptr = 0;
    endtask

    // Entered and left at a negedge; drives one accepted call and checks it.
    task automatic do_call(input logic [31:0] a, input logic [31:0] b, input int stall,
                           input int hold, input bit noise, output logic [31:0] res);
        int lat;
        int exp_lat;
        logic [31:0] exp_res;
        if (b[0]) model_clear();
        if (!b[1]) begin
            mpack[2 * mptr]     = gray_ref(a[15:0]);
            mpack[2 * mptr + 1] = gray_ref(a[31:16]);
            mptr = 1 - mptr;
        end
        exp_res = model_word();
        exp_lat = b[1] ? 1 : 3 + stall;

        ciN = ID; ciValueA = a; ciValueB = b; ciStart = 1'b1; ciCke = 1'b1;
        @(negedge clock);
        ciStart = 1'b0;
        lat = 1;
        if (!b[1] && stall > 0) begin
            ciCke = 1'b0;
            repeat (stall) begin
                @(negedge clock);
                lat++;
            end
            ciCke = 1'b1;
        end
        while (!ciDone && lat < 40) begin
            check("result_zero_while_busy", ciResult, 32'h0);
            if (noise) begin
                ciStart  = 1'($urandom_range(0, 1));
                ciValueA = $urandom;
                ciValueB = $urandom;
            end
            @(negedge clock);
            lat++;
        end
        ciStart = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("done", {31'b0, ciDone}, 32'h1);
        check("result", ciResult, exp_res);
        res = ciResult;
        if (hold > 0) begin
            ciCke = 1'b0;
            repeat (hold) @(negedge clock);
            check("done_held", {31'b0, ciDone}, 32'h1);
            check("result_held", ciResult, exp_res);
            ciCke = 1'b1;
        end
        @(negedge clock);
        check("done_drop", {31'b0, ciDone}, 32'h0);
        check("result_drop", ciResult, 32'h0);
    endtask

    task automatic bad_start(input int cycles);
        ciN = ID + 8'd1; ciStart = 1'b1; ciCke = 1'b1;
        ciValueA = $urandom; ciValueB = 32'h0;
        repeat (cycles) begin
            @(negedge clock);
            check("mismatch_no_done", {31'b0, ciDone}, 32'h0);
            check("mismatch_result", ciResult, 32'h0);
        end
        ciStart = 1'b0; ciN = ID;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a, b;
        reset = 1'b1; ciStart = 1'b0; ciCke = 1'b1; ciN = ID;
        ciValueA = '0; ciValueB = '0;
        model_clear();
        repeat (3) @(negedge clock);
        check("reset_done", {31'b0, ciDone}, 32'h0);
        check("reset_result", ciResult, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        do_call(32'hF800FFFF, 32'h1, 0, 0, 1'b0, r);
        check("t1_word", r, 32'h000034FA);
        do_call(32'h001F07E0, 32'h0, 0, 0, 1'b0, r);
        check("t2_word", r, 32'h12B434FA);
        do_call(32'h00000000, 32'h0, 0, 0, 1'b0, r);
        check("t3_wrap", r, 32'h12B40000);
        do_call(32'hDEADBEEF, 32'h2, 0, 1, 1'b0, r);
        check("t4_readonly", r, 32'h12B40000);

        bad_start(3);
        do_call(32'h0, 32'h2, 0, 0, 1'b0, r);
        check("t5_unchanged", r, 32'h12B40000);

        // Reset while the second pixel is being converted.
        ciN = ID; ciValueA = 32'hFFFFFFFF; ciValueB = 32'h0; ciStart = 1'b1;
        @(negedge clock);
        ciStart = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (4) begin
            @(negedge clock);
            check("t6_no_done", {31'b0, ciDone}, 32'h0);
        end
        do_call(32'h0, 32'h2, 0, 0, 1'b0, r);
        check("t6_cleared", r, 32'h00000000);

        do_call(32'hF800FFFF, 32'h1, 4, 0, 1'b0, r);
        check("t7_stall_word", r, 32'h000034FA);

        do_call(32'h12345678, 32'h3, 0, 0, 1'b0, r);
        check("clear_readonly", r, 32'h00000000);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = $urandom;
            b[0] = ($urandom_range(0, 3) == 0);
            b[1] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) bad_start(int'($urandom_range(1, 2)));
            do_call(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
